// File: rtl/output_line_uart_tx_pkg.sv
// Shared definitions for the output-line UART transmitter: word/byte widths
// and the transmit FSM state encoding.
package output_uart_pkg;

  localparam int LINE_WIDTH = 16;
  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

endpackage

// File: rtl/output_line_uart_tx_sync_fifo.sv
// Single-clock show-ahead FIFO; an explicit occupancy count keeps full and
// empty distinct while the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  assign dout  = mem[rdPtr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/output_line_uart_tx.sv
// Buffers 16-bit output-line words and sends each as two 8N1 frames,
// low byte first, on the txd pin.
module output_line_uart_tx
  import output_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LINE_WIDTH-1:0]         lineData,
  input  logic                          lineWrite,
  output logic                          txd,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

  txState_t               state;
  txState_t               stateNext;
  logic [TIMER_W-1:0]     bitTimer;
  logic [2:0]             bitCount;
  logic [2:0]             bitNext;
  logic                   byteIndex;
  logic [LINE_WIDTH-1:0]  shiftReg;
  logic [BYTE_WIDTH-1:0]  curByte;
  logic [LINE_WIDTH-1:0]  fifoDout;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic                   pop;
  logic                   pushAccepted;
  logic                   bitDone;
  logic [CNT_W-1:0]       countNext;

  assign pop          = (state == IDLE) && !fifoEmpty;
  assign pushAccepted = lineWrite && (!fifoFull || pop);
  assign bitDone      = (bitTimer == TIMER_LAST);
  assign bitNext      = bitCount + 3'd1;
  assign curByte      = shiftReg[BYTE_WIDTH-1:0];
  assign countNext    = fifoCount + CNT_W'(pushAccepted) - CNT_W'(pop);

  sync_fifo #(
    .WIDTH (LINE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) lineFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pushAccepted),
    .pop   (pop),
    .din   (lineData),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // The low-byte stop bit chains straight into the high-byte start bit.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (!fifoEmpty) stateNext = START;
      START: if (bitDone) stateNext = DATA;
      DATA:  if (bitDone && bitCount == 3'd7) stateNext = STOP;
      STOP:  if (bitDone) stateNext = byteIndex ? IDLE : START;
      default: stateNext = IDLE;
    endcase
  end

  // busy looks ahead one edge so it drops on the first idle-and-empty cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bitTimer  <= '0;
      bitCount  <= '0;
      byteIndex <= 1'b0;
      shiftReg  <= '0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext != IDLE) || (countNext != '0);
      if (lineWrite && fifoFull && !pop) overflow <= 1'b1;

      if (state == IDLE || bitDone) bitTimer <= '0;
      else                          bitTimer <= bitTimer + 1'b1;

      case (state)
        IDLE: begin
          txd <= fifoEmpty;
          if (!fifoEmpty) begin
            shiftReg  <= fifoDout;
            byteIndex <= 1'b0;
            bitCount  <= '0;
          end
        end
        START: begin
          if (bitDone) txd <= curByte[0];
        end
        DATA: begin
          if (bitDone) begin
            bitCount <= bitNext;
            txd      <= (bitCount == 3'd7) ? 1'b1 : curByte[bitNext];
          end
        end
        STOP: begin
          if (bitDone && !byteIndex) begin
            byteIndex <= 1'b1;
            shiftReg  <= {{BYTE_WIDTH{1'b0}}, shiftReg[LINE_WIDTH-1:BYTE_WIDTH]};
            txd       <= 1'b0;
          end
        end
        default: txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_output_line_uart_tx.sv
// Directed bench for output_line_uart_tx: a line monitor decodes 8N1 frames
// and compares them against bytes queued when each word was written.
module tb_output_line_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lineData = '0;
  logic        lineWrite = 1'b0;
  logic        txd;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifoCount;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];

  int         monPos = -1;
  logic       monPrev = 1'b1;
  logic [7:0] monByte;
  logic [7:0] expByte;
  logic       stayedHigh;

  output_line_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lineData  (lineData),
    .lineWrite (lineWrite),
    .txd       (txd),
    .busy      (busy),
    .overflow  (overflow),
    .fifoCount (fifoCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    lineWrite = 1'b0;
    ticks(2);
    rst = 1'b0;
    sb.delete();
  endtask

  // One write strobe; accepted words queue their two bytes, low first.
  task automatic applyStimulus(input logic [15:0] d, input bit accepted);
    lineData  = d;
    lineWrite = 1'b1;
    tick();
    lineWrite = 1'b0;
    if (accepted) begin
      sb.push_back(d[7:0]);
      sb.push_back(d[15:8]);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("idle within budget", 16'(busy !== 1'b0), 16'd0);
  endtask

  // Frame decoder: start detected at pos 0, bits sampled mid-cell.
  always @(negedge clk) begin
    if (rst) begin
      monPos = -1;
    end else if (monPos < 0) begin
      if (txd === 1'b0 && monPrev === 1'b1) monPos = 0;
    end else begin
      monPos++;
      if (monPos == CPB / 2) checkOutput("start bit", 16'(txd), 16'd0);
      if (monPos >= CPB + CPB / 2 && monPos < 9 * CPB && (monPos - CPB - CPB / 2) % CPB == 0)
        monByte[(monPos - CPB - CPB / 2) / CPB] = txd;
      if (monPos == 9 * CPB + CPB / 2) begin
        checkOutput("stop bit", 16'(txd), 16'd1);
        checkOutput("frame expected", 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
          expByte = sb.pop_front();
          checkOutput("frame byte", 16'(monByte), 16'(expByte));
        end
        monPos = -1;
      end
    end
    monPrev = txd;
  end

  initial begin
    $display("[TB] reset");
    doReset();
    checkOutput("reset txd", 16'(txd), 16'd1);
    checkOutput("reset busy", 16'(busy), 16'd0);
    checkOutput("reset overflow", 16'(overflow), 16'd0);
    checkOutput("reset fifoCount", 16'(fifoCount), 16'd0);

    $display("[TB] single word A55A");
    applyStimulus(16'hA55A, 1'b1);
    checkOutput("single count after write", 16'(fifoCount), 16'd1);
    checkOutput("single txd idle after write", 16'(txd), 16'd1);
    tick();
    checkOutput("single txd start", 16'(txd), 16'd0);
    checkOutput("single count after pop", 16'(fifoCount), 16'd0);
    checkOutput("single busy", 16'(busy), 16'd1);
    ticks(20 * CPB - 1);
    checkOutput("single busy before end", 16'(busy), 16'd1);
    tick();
    checkOutput("single busy after end", 16'(busy), 16'd0);
    checkOutput("single txd after end", 16'(txd), 16'd1);
    checkOutput("single frames drained", 16'(sb.size()), 16'd0);

    $display("[TB] burst of six");
    doReset();
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(16'(i), i < 6);
      checkOutput("burst overflow", 16'(overflow), 16'(i == 6));
    end
    checkOutput("burst count full", 16'(fifoCount), 16'd4);
    waitIdle(1000);
    checkOutput("burst overflow sticky", 16'(overflow), 16'd1);
    checkOutput("burst frames drained", 16'(sb.size()), 16'd0);

    $display("[TB] write while full with pop");
    doReset();
    for (int i = 1; i <= 5; i++) applyStimulus(16'(16'h0100 + i), 1'b1);
    checkOutput("full count", 16'(fifoCount), 16'd4);
    ticks(20 * CPB - 3);
    checkOutput("full count at idle", 16'(fifoCount), 16'd4);
    checkOutput("full txd at idle", 16'(txd), 16'd1);
    applyStimulus(16'h0107, 1'b1);
    checkOutput("push+pop count", 16'(fifoCount), 16'd4);
    checkOutput("push+pop overflow", 16'(overflow), 16'd0);
    checkOutput("push+pop txd start", 16'(txd), 16'd0);
    waitIdle(1000);
    checkOutput("push+pop overflow end", 16'(overflow), 16'd0);
    checkOutput("push+pop frames drained", 16'(sb.size()), 16'd0);

    $display("[TB] back-to-back words");
    doReset();
    applyStimulus(16'h1234, 1'b1);
    applyStimulus(16'hBEEF, 1'b1);
    ticks(20 * CPB - 1);
    checkOutput("b2b stop bit", 16'(txd), 16'd1);
    tick();
    checkOutput("b2b idle gap", 16'(txd), 16'd1);
    checkOutput("b2b count before pop", 16'(fifoCount), 16'd1);
    tick();
    checkOutput("b2b second start", 16'(txd), 16'd0);
    checkOutput("b2b count after pop", 16'(fifoCount), 16'd0);
    waitIdle(500);
    checkOutput("b2b frames drained", 16'(sb.size()), 16'd0);

    $display("[TB] reset mid-frame");
    doReset();
    applyStimulus(16'h0000, 1'b1);
    applyStimulus(16'h0000, 1'b1);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("midrst queued", 16'(fifoCount), 16'd2);
    ticks(CPB + 4);
    checkOutput("midrst txd low in data", 16'(txd), 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    checkOutput("midrst txd", 16'(txd), 16'd1);
    checkOutput("midrst fifoCount", 16'(fifoCount), 16'd0);
    checkOutput("midrst busy", 16'(busy), 16'd0);
    stayedHigh = 1'b1;
    for (int i = 0; i < 50 * CPB; i++) begin
      tick();
      if (txd !== 1'b1) stayedHigh = 1'b0;
    end
    checkOutput("midrst line stays idle", 16'(stayedHigh), 16'd1);
    checkOutput("midrst busy after", 16'(busy), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_line_uart_tx.md
# output_line_uart_tx

Serialises the CPU core's 16-bit output-line words onto a UART transmit pin. Sits directly downstream of the processor top: its `lineData`/`lineWrite` inputs connect to the core's output line and output-line write strobe, both in the same clock domain. Writes are buffered in a FIFO so bursts of `outputLine` writes are not lost while the slow serial link drains them. Each word is sent as two 8N1 frames, low byte first.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 16, FIFO depth in words; must be a power of two ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `lineData`  in  16  word written by the core.
- `lineWrite`  in  1  write strobe; one word is captured per cycle the strobe is high.
- `txd`  out  1  serial output; idle high.
- `busy`  out  1  high while the FIFO is non-empty or the FSM is not in IDLE.
- `overflow`  out  1  sticky; set when a write arrives while the FIFO is full.
- `fifoCount`  out  $clog2(FIFO_DEPTH)+1  number of buffered words.

## Operation
- FIFO push: `lineWrite` high and FIFO not full (or full with a pop in the same cycle) -> `lineData` stored; count +1.
- Write while full with no pop -> word dropped; `overflow` set; it stays set until `rst`.
- Simultaneous push and pop -> both occur; count unchanged.
- FSM states and transitions:
  - IDLE -> START when FIFO is non-empty. The head word is popped into a 16-bit shift register. The byte index is cleared.
  - START: `txd`=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles -> STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles. Then:
    - if byte index = 0: set index to 1, shift the high byte down, go -> START (no IDLE gap);
    - otherwise -> IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. The bit counter is 3 bits and wraps 7->0 on the transition to STOP.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is derived separately so that full is distinguishable from empty.

## Timing
- Reset values: `txd`=1, `busy`=0, `overflow`=0, `fifoCount`=0. FSM is in IDLE, FIFO is empty, and all counters are 0.
- Reset mid-frame: on the edge where `rst` is high, `txd` returns to 1, the FIFO is flushed, and any in-flight word is discarded.
- Latency (FIFO empty and FSM in IDLE):
  - write at edge N -> `fifoCount`=1 after N;
  - pop at edge N+1 -> `txd` falls after N+1; `fifoCount`=0.
- Word duration: 20·CLKS_PER_BIT cycles from the first start bit to the end of the second stop bit.
- Back-to-back words: exactly one IDLE cycle between the end of the high-byte stop bit and the next start bit.
- `busy` is registered. It falls on the first IDLE cycle with an empty FIFO.
- `overflow` is set on the edge that drops the word.

## Structure
- Shared package `output_uart_pkg`:
  - state enum {IDLE, START, DATA, STOP};
  - constant `LINE_WIDTH`=16 and byte width 8.
- Sub-module `sync_fifo`:
  - parameterised by WIDTH and DEPTH;
  - ports `clk`, `rst`, push, pop, din, dout (head, show-ahead), full, empty, count.
- The top holds the FSM, the bit timer, the shift register and the overflow flag.

## Test plan
All scenarios run with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset: hold `rst` 2 cycles -> `txd`=1, `busy`=0, `overflow`=0, `fifoCount`=0.
- Single word 0xA55A:
  - `txd` falls 2 edges after the strobe;
  - line carries frame 0x5A (bits 0,1,0,1,1,0,1,0 LSB-first), then frame 0xA5;
  - each bit lasts 4 cycles, total 80 cycles;
  - then `busy`=0.
- Burst of 6 consecutive writes 0x0001..0x0006 while idle:
  - first word is popped the cycle after it is written, so words 1..5 are accepted and word 6 is dropped;
  - `overflow`=1 from the 6th write edge onward;
  - serial output = 01 00 02 00 03 00 04 00 05 00.
- Write on the same cycle as a pop while full: `fifoCount` stays at 4 and no overflow.
- Back-to-back words 0x1234 and 0xBEEF: exactly 1 idle-high cycle between the 0x12 stop bit and the 0xEF start bit.
- `rst` asserted in the DATA state of the low byte with 2 words queued:
  - next cycle `txd`=1 and `fifoCount`=0;
  - no further frames are sent.
